// File: rtl/pulse_event_scheduler_pkg.sv
// Shared types and constants for the pulse event scheduler.
package pulse_event_scheduler_pkg;

    localparam int EV_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_event_scheduler_if.sv
// Event-request / synchronizer-issue bundle between the logical layer and the scheduler.
interface pulse_event_scheduler_if;
    import pulse_event_scheduler_pkg::*;

    logic [EV_N-1:0] ev_req;
    logic            busy;
    logic [EV_N-1:0] sig_3bit;
    logic [EV_N-1:0] pending;
    logic [EV_N-1:0] overflow;
    logic            idle;

    modport slave (
        input  ev_req,
        input  busy,
        output sig_3bit,
        output pending,
        output overflow,
        output idle
    );

    modport master (
        output ev_req,
        output busy,
        input  sig_3bit,
        input  pending,
        input  overflow,
        input  idle
    );

endinterface

// File: rtl/pulse_event_scheduler_sat_counter.sv
// Per-channel pending-request counter: saturates at all-ones, flags requests lost to saturation.
module sat_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unique case ({inc, dec})
                2'b10: begin
                    if (cnt == CNT_MAX) ovf <= 1'b1;
                    else                cnt <= cnt + CNT_ONE;
                end
                2'b01: begin
                    if (cnt != '0) cnt <= cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pulse_event_scheduler.sv
// Fast-domain scheduler: counts per-channel event requests and issues them as
// single-cycle pulses to the pulse synchronizer, paced by its busy handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | free; issues all pending channels together when busy is low
// WAIT_HI  | after issue, waiting for busy to rise (bounded by BUSY_TO)
// WAIT_LO  | waiting for busy to fall
// HOLD     | enforcing GAP idle cycles before returning to IDLE
module pulse_event_scheduler
    import pulse_event_scheduler_pkg::*;
#(
    parameter int CNT_W   = 3,
    parameter int BUSY_TO = 4,
    parameter int GAP     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    pulse_event_scheduler_if.slave bus
);

    localparam int TMR_MAX = (BUSY_TO > GAP) ? BUSY_TO : GAP;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] BUSY_TO_LD = TMR_W'(BUSY_TO);
    localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(GAP);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmo_q, tmo_d;
    logic [TMR_W-1:0] gap_q, gap_d;
    logic [EV_N-1:0]  sig_q;
    logic [EV_N-1:0]  issue;
    logic [EV_N-1:0]  pend;
    logic [EV_N-1:0]  ovf;
    logic [CNT_W-1:0] cnt [EV_N];

    for (genvar i = 0; i < EV_N; i++) begin : g_ch
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (bus.ev_req[i]),
            .dec (issue[i]),
            .cnt (cnt[i]),
            .ovf (ovf[i])
        );
        assign pend[i] = |cnt[i];
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        issue   = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Issue mask comes from counters, so same-cycle new requests wait a round.
                if ((|pend) && !bus.busy) begin
                    issue   = pend;
                    tmo_d   = BUSY_TO_LD;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tmo_q != '0) tmo_d = tmo_q - TMR_ONE;
                if (bus.busy || (tmo_q <= TMR_ONE)) state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!bus.busy) begin
                    gap_d   = GAP_LD;
                    state_d = (GAP == 0) ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (gap_q != '0) gap_d = gap_q - TMR_ONE;
                if (gap_q <= TMR_ONE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            gap_q   <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            sig_q   <= issue;
        end
    end

    assign bus.sig_3bit = sig_q;
    assign bus.pending  = pend;
    assign bus.overflow = ovf;
    assign bus.idle     = (state_q == ST_IDLE) && !(|pend);

endmodule

// File: tb/tb_pulse_event_scheduler.sv
// Bench for pulse_event_scheduler: hand-derived vector table, directed corner
// sequences and randomized traffic against a timestamp-based reference model.
module tb_pulse_event_scheduler;

    localparam int CNT_W   = 3;
    localparam int BUSY_TO = 4;
    localparam int GAP     = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    pulse_event_scheduler_if ifc();

    pulse_event_scheduler #(
        .CNT_W   (CNT_W),
        .BUSY_TO (BUSY_TO),
        .GAP     (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: pending counts plus timestamps of when the scheduler
    // may next issue (phase 0 free, 1 awaiting busy rise, 2 awaiting busy fall, 3 gap).
    int         cnt_m [3];
    int         ph;
    int         t_edge = 0;
    int         t_dead;
    int         t_free;
    logic [2:0] m_sig;
    logic [2:0] m_ovf;

    function automatic logic [2:0] m_pend();
        logic [2:0] p;
        for (int i = 0; i < 3; i++) p[i] = (cnt_m[i] > 0);
        return p;
    endfunction

    function automatic logic m_idle();
        return (ph == 0) && (m_pend() == 3'b000);
    endfunction

    task automatic model_edge(input logic [2:0] ev, input logic b, input logic r);
        logic [2:0] mask;
        t_edge++;
        m_sig = '0;
        m_ovf = '0;
        mask  = '0;
        if (!r) begin
            for (int i = 0; i < 3; i++) cnt_m[i] = 0;
            ph = 0;
            return;
        end
        if (ph == 0 && !b) mask = m_pend();
        if (mask != 3'b000) begin
            ph     = 1;
            t_dead = t_edge + ((BUSY_TO < 1) ? 1 : BUSY_TO);
        end else if (ph == 1) begin
            if (b || t_edge >= t_dead) ph = 2;
        end else if (ph == 2) begin
            if (!b) begin
                if (GAP == 0) ph = 0;
                else begin
                    ph     = 3;
                    t_free = t_edge + GAP;
                end
            end
        end else if (ph == 3) begin
            if (t_edge >= t_free) ph = 0;
        end
        m_sig = mask;
        for (int i = 0; i < 3; i++) begin
            if (ev[i] && !mask[i]) begin
                if (cnt_m[i] == CMAX) m_ovf[i] = 1'b1;
                else                  cnt_m[i]++;
            end else if (!ev[i] && mask[i]) begin
                cnt_m[i]--;
            end
        end
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got sig/pend/ovf/idle=%b want=%b", name, t_edge, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {ifc.sig_3bit, ifc.pending, ifc.overflow, ifc.idle};
    endfunction

    task automatic step(input logic [2:0] ev, input logic b, input logic r, input bit mchk);
        ifc.ev_req = ev;
        ifc.busy   = b;
        rst        = r;
        @(posedge clk);
        model_edge(ev, b, r);
        #1;
        if (mchk) chk("model", dut_out(), {m_sig, m_pend(), m_ovf, m_idle()});
    endtask

    typedef struct packed {
        logic [2:0] ev;
        logic       busy;
        logic       r;
        logic [2:0] sig;
        logic [2:0] pend;
        logic [2:0] ovf;
        logic       idle;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] ev, input logic b, input logic r,
                       input logic [2:0] sig, input logic [2:0] pend,
                       input logic [2:0] ovf, input logic idle);
        vec_t v;
        v.ev = ev; v.busy = b; v.r = r;
        v.sig = sig; v.pend = pend; v.ovf = ovf; v.idle = idle;
        vecs.push_back(v);
    endtask

    initial begin
        int         pulses;
        int         ovfs;
        int         last_t;
        int         min_sp;
        int         busy_left;
        logic [2:0] ev;
        logic       b;
        logic       r;

        ifc.ev_req = '0;
        ifc.busy   = 1'b0;
        rst        = 1'b0;
        for (int i = 0; i < 3; i++) cnt_m[i] = 0;
        ph = 0;

        // ev busy rst | sig pend ovf idle
        add(3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 1);  // reset
        add(3'b010, 0, 1, 3'b000, 3'b010, 3'b000, 0);  // single request counted
        add(3'b000, 0, 1, 3'b010, 3'b000, 3'b000, 0);  // issued 2 edges after request
        add(3'b000, 1, 1, 3'b000, 3'b000, 3'b000, 0);
        add(3'b000, 1, 1, 3'b000, 3'b000, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 1);  // back to idle after gap
        add(3'b101, 0, 1, 3'b000, 3'b101, 3'b000, 0);  // ch0+ch2 together
        add(3'b010, 0, 1, 3'b101, 3'b010, 3'b000, 0);  // joint issue; new ch1 held back
        add(3'b000, 0, 1, 3'b000, 3'b010, 3'b000, 0);  // busy never rises from here
        add(3'b000, 0, 1, 3'b000, 3'b010, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b010, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b010, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b010, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b010, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b010, 3'b000, 0);
        add(3'b000, 0, 1, 3'b010, 3'b000, 3'b000, 0);  // timeout path: 7 quiet cycles between pulses
        add(3'b000, 1, 1, 3'b000, 3'b000, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 0);
        add(3'b000, 0, 1, 3'b000, 3'b000, 3'b000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ev, vecs[i].busy, vecs[i].r, 1'b0);
            chk($sformatf("vec%0d", i), dut_out(),
                {vecs[i].sig, vecs[i].pend, vecs[i].ovf, vecs[i].idle});
        end

        // Saturation: 9 requests on ch1 while busy holds the scheduler in IDLE.
        ovfs = 0;
        for (int k = 0; k < 9; k++) begin
            step(3'b010, 1'b1, 1'b1, 1'b1);
            if (ifc.overflow[1]) ovfs++;
            chk_int($sformatf("sat_ovf%0d", k), int'(ifc.overflow), (k >= 7) ? 2 : 0);
        end
        chk_int("sat_ovf_count", ovfs, 2);
        pulses = 0;
        for (int k = 0; k < 120; k++) begin
            step(3'b000, 1'b0, 1'b1, 1'b1);
            if (ifc.sig_3bit == 3'b010) pulses++;
        end
        chk_int("sat_issues", pulses, 7);
        chk_int("sat_idle", int'(ifc.idle), 1);

        // Three back-to-back ch0 requests, busy answers each issue for 5 cycles.
        pulses    = 0;
        busy_left = 0;
        last_t    = -1000;
        min_sp    = 1000;
        for (int c = 0; c < 80; c++) begin
            step((c < 3) ? 3'b001 : 3'b000, busy_left > 0, 1'b1, 1'b1);
            if (busy_left > 0) busy_left--;
            if (ifc.sig_3bit == 3'b001) begin
                pulses++;
                if (t_edge - last_t < min_sp) min_sp = t_edge - last_t;
                last_t    = t_edge;
                busy_left = 5;
            end
        end
        chk_int("b2b_pulses", pulses, 3);
        chk_int("b2b_spacing_ok", int'(min_sp >= 5 + GAP + 2), 1);

        // Reset while in WAIT_LO with counts {2,1,0}.
        step(3'b100, 1'b0, 1'b1, 1'b1);
        step(3'b000, 1'b0, 1'b1, 1'b1);
        step(3'b011, 1'b1, 1'b1, 1'b1);
        step(3'b001, 1'b1, 1'b1, 1'b1);
        chk_int("rst_pre_pending", int'(ifc.pending), 3);
        step(3'b000, 1'b1, 1'b0, 1'b1);
        chk("rst_outputs", dut_out(), 10'b000_000_000_1);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            step(3'b000, 1'b0, 1'b1, 1'b1);
            if (ifc.sig_3bit != 3'b000) pulses++;
        end
        chk_int("rst_no_pulse", pulses, 0);

        // Randomized traffic against the reference model.
        b = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) b = ~b;
            ev = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            r  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step(ev, b, r, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
